multiplier_nbit: RTL and testbench
==================================

MULTIPLIER_NBIT -- requirements
Module: multiplier_nbit

Interface
REQ-001 Parameter N, default 8, operand and result width in bits; N SHALL be legal for 2..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands on in_a/in_b are to be captured this cycle.
REQ-005 in_a  input  N  unsigned multiplicand.
REQ-006 in_b  input  N  unsigned multiplier.
REQ-007 out  output  N  low N bits of in_a*in_b.
REQ-008 cout  output  1  overflow flag: 1 when the full 2N-bit product has any nonzero bit at position N or above.
REQ-009 out_valid  output  1  out/cout hold a result computed from a captured operand pair.

Function
REQ-010 The product SHALL be unsigned; full product P = in_a*in_b is 2N bits wide.
REQ-011 On a rising clk edge with in_valid=1, out SHALL load P[N-1:0] and cout SHALL load (P[2N-1:N] != 0).
REQ-012 Latency SHALL be exactly one cycle: the result is visible on the edge that samples in_valid=1.
REQ-013 out_valid SHALL be a register loaded with in_valid each edge.
REQ-014 With in_valid=0, out and cout SHALL hold their previous values; out_valid SHALL fall to 0.
REQ-015 Throughput SHALL be one operation per cycle; back-to-back in_valid=1 cycles SHALL each produce an independent result.
REQ-016 Either operand zero SHALL give out=0, cout=0.
REQ-017 Operand 1 SHALL pass the other operand through unchanged with cout=0.
REQ-018 Maximum operands (2^N-1)*(2^N-1) SHALL give out=1 and cout=1.
REQ-019 cout SHALL reflect only the captured product; no sticky accumulation between operations.
REQ-020 The product SHALL be formed combinationally between the input pins and the output registers by a shift-and-add array (N partial-product rows).
REQ-021 No behavioural "*" operator SHALL be used.
REQ-022 Outputs SHALL never be X after reset for any 0/1 inputs.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force out=0, cout=0 and out_valid=0.
REQ-024 During reset, in_valid SHALL be ignored.
REQ-025 The first capture SHALL be the first rising edge with rst_n=1 and in_valid=1.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result, with no output glitch to a stale value after release.

Structure
REQ-027 No shared package is required.
REQ-028 N SHALL be a module parameter only.
REQ-029 One sub-module, mult_add_row, SHALL be used: an N-bit ripple-carry adder row (partial-product AND gating plus full adders, carry out).
REQ-030 The sub-module SHALL be instantiated N-1 times via a generate loop.
REQ-031 Output flops SHALL live in the top module.

Verification
REQ-032 Scenario 1 (N=7): reset low, then release; a=0, b=0, in_valid=1 -> next edge out=0000000, cout=0, out_valid=1.
REQ-033 Scenario 2 (N=7): a=1, b=0 then a=1, b=1 back-to-back -> out=0 then out=0000001, cout=0 on consecutive cycles.
REQ-034 Scenario 3 (N=7): a=3, b=4 -> out=0001100, cout=0; a=15, b=15 -> out=1100001 (225 mod 128 = 97), cout=1.
REQ-035 Scenario 4 (N=7): a=127, b=127 -> out=0000001, cout=1; a=64, b=2 -> out=0, cout=1.
REQ-036 Scenario 5: in_valid deasserted after a result -> out/cout hold and out_valid=0; rst_n pulsed low between edges -> outputs 0 asynchronously.
REQ-037 Scenario 6 (N=8 default): exhaustive or random sweep of 10k operand pairs against a 2N-bit reference model -> all out/cout match.

Source files
------------

// File: rtl/multiplier_nbit_pkg.sv
// Shared types and helpers for the N-bit shift-and-add multiplier.
// Provides the single-bit full-adder primitive used by the adder rows.
package multiplier_nbit_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef struct packed {
        logic c;
        logic s;
    } fa_t;

    function automatic fa_t full_add(
        input logic a,
        input logic b,
        input logic ci
    );
        fa_t r;
        r.s = a ^ b ^ ci;
        r.c = (a & b) | (a & ci) | (b & ci);
        return r;
    endfunction

endpackage

// File: rtl/multiplier_nbit_mult_add_row.sv
// One row of the multiplier array: gates the multiplicand with one
// multiplier bit and ripple-adds it onto the running partial sum.
// Ports: i_a (multiplicand), i_bit (multiplier bit), i_sum (partial
// sum in), o_sum (N-bit sum out), o_carry (carry out of the row).
module mult_add_row
    import multiplier_nbit_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic         i_bit,
    input  logic [N-1:0] i_sum,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N-1:0] w_pp;
    assign w_pp = i_a & {N{i_bit}};

    always_comb begin
        logic c;
        fa_t  r;
        o_sum = '0;
        c     = 1'b0;
        for (int k = 0; k < N; k++) begin
            r        = full_add(i_sum[k], w_pp[k], c);
            o_sum[k] = r.s;
            c        = r.c;
        end
        o_carry = c;
    end

endmodule

// File: rtl/multiplier_nbit.sv
// Unsigned N x N multiplier, combinational shift-and-add array with
// registered low-half result, overflow flag and valid, 1-cycle latency.
// Ports: clk, rst_n (async low), in_valid, in_a, in_b -> out, cout,
// out_valid.
module multiplier_nbit
    import multiplier_nbit_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         out_valid
);

    // w_row[i] = {carry, sum} after folding in multiplier bit i.
    // Bit 0 of each row is final product bit i; bits [N:1] feed
    // the next row (the shift of shift-and-add).
    logic [N:0]   w_row [N];
    logic [N-1:0] w_p_lo;
    logic [N-1:0] w_p_hi;

    assign w_row[0] = {1'b0, in_a & {N{in_b[0]}}};

    for (genvar i = 1; i < N; i++) begin : g_row
        mult_add_row #(.N(N)) u_row (
            .i_a     (in_a),
            .i_bit   (in_b[i]),
            .i_sum   (w_row[i-1][N:1]),
            .o_sum   (w_row[i][N-1:0]),
            .o_carry (w_row[i][N])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_lo
        assign w_p_lo[i] = w_row[i][0];
    end

    assign w_p_hi = w_row[N-1][N:1];

    logic [N-1:0] r_out;
    logic         r_cout;
    logic         r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out  <= w_p_lo;
                r_cout <= |w_p_hi;
            end
        end
    end

    assign out       = r_out;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_multiplier_nbit.sv
// Directed and swept checks of multiplier_nbit at N=7 and N=8.
// Scenario tasks run in sequence and compare inline.
module tb_multiplier_nbit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v7 = 1'b0;
    logic [6:0] a7 = '0;
    logic [6:0] b7 = '0;
    logic [6:0] o7;
    logic       c7;
    logic       ov7;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] o8;
    logic       c8;
    logic       ov8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_nbit #(.N(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v7),
        .in_a      (a7),
        .in_b      (b7),
        .out       (o7),
        .cout      (c7),
        .out_valid (ov7)
    );

    multiplier_nbit #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_a      (a8),
        .in_b      (b8),
        .out       (o8),
        .cout      (c8),
        .out_valid (ov8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive7(input logic v, input int a, input int b);
        v7 = v;
        a7 = 7'(a);
        b7 = 7'(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive7(1'b1, 5, 5);
        step();
        checks++;
        if ({o7, c7, ov7} !== 9'b0) begin
            errors++;
            $display("FAIL reset: out=%0d cout=%b ov=%b want 0 0 0",
                     o7, c7, ov7);
        end
        checks++;
        if ({o8, c8, ov8} !== 10'b0) begin
            errors++;
            $display("FAIL reset8: out=%0d cout=%b ov=%b want 0 0 0",
                     o8, c8, ov8);
        end
        drive7(1'b0, 0, 0);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero();
        drive7(1'b1, 0, 0);
        step();
        checks++;
        if (o7 !== 7'd0 || c7 !== 1'b0 || ov7 !== 1'b1) begin
            errors++;
            $display("FAIL zero: out=%0d cout=%b ov=%b want 0 0 1",
                     o7, c7, ov7);
        end
    endtask

    task automatic test_back_to_back();
        drive7(1'b1, 1, 0);
        step();
        checks++;
        if (o7 !== 7'd0 || c7 !== 1'b0 || ov7 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_1x0: out=%0d cout=%b ov=%b want 0 0 1",
                     o7, c7, ov7);
        end
        drive7(1'b1, 1, 1);
        step();
        checks++;
        if (o7 !== 7'd1 || c7 !== 1'b0 || ov7 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_1x1: out=%0d cout=%b ov=%b want 1 0 1",
                     o7, c7, ov7);
        end
        drive7(1'b1, 45, 1);
        step();
        checks++;
        if (o7 !== 7'd45 || c7 !== 1'b0) begin
            errors++;
            $display("FAIL pass_a: out=%0d cout=%b want 45 0", o7, c7);
        end
        drive7(1'b1, 0, 99);
        step();
        checks++;
        if (o7 !== 7'd0 || c7 !== 1'b0) begin
            errors++;
            $display("FAIL zero_a: out=%0d cout=%b want 0 0", o7, c7);
        end
    endtask

    task automatic test_basic();
        drive7(1'b1, 3, 4);
        step();
        checks++;
        if (o7 !== 7'd12 || c7 !== 1'b0) begin
            errors++;
            $display("FAIL 3x4: out=%0d cout=%b want 12 0", o7, c7);
        end
        drive7(1'b1, 15, 15);
        step();
        checks++;
        if (o7 !== 7'd97 || c7 !== 1'b1) begin
            errors++;
            $display("FAIL 15x15: out=%0d cout=%b want 97 1", o7, c7);
        end
        drive7(1'b1, 10, 12);
        step();
        checks++;
        if (o7 !== 7'd120 || c7 !== 1'b0) begin
            errors++;
            $display("FAIL 10x12: out=%0d cout=%b want 120 0", o7, c7);
        end
    endtask

    task automatic test_overflow();
        drive7(1'b1, 127, 127);
        step();
        checks++;
        if (o7 !== 7'd1 || c7 !== 1'b1) begin
            errors++;
            $display("FAIL 127x127: out=%0d cout=%b want 1 1", o7, c7);
        end
        drive7(1'b1, 64, 2);
        step();
        checks++;
        if (o7 !== 7'd0 || c7 !== 1'b1) begin
            errors++;
            $display("FAIL 64x2: out=%0d cout=%b want 0 1", o7, c7);
        end
        drive7(1'b1, 64, 1);
        step();
        checks++;
        if (o7 !== 7'd64 || c7 !== 1'b0) begin
            errors++;
            $display("FAIL nosticky: out=%0d cout=%b want 64 0", o7, c7);
        end
    endtask

    task automatic test_hold_and_async_reset();
        drive7(1'b1, 15, 15);
        step();
        drive7(1'b0, 3, 3);
        step();
        checks++;
        if (o7 !== 7'd97 || c7 !== 1'b1 || ov7 !== 1'b0) begin
            errors++;
            $display("FAIL hold: out=%0d cout=%b ov=%b want 97 1 0",
                     o7, c7, ov7);
        end
        drive7(1'b1, 5, 6);
        step();
        checks++;
        if (o7 !== 7'd30 || ov7 !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: out=%0d ov=%b want 30 1", o7, ov7);
        end
        drive7(1'b1, 9, 9);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o7, c7, ov7} !== 9'b0) begin
            errors++;
            $display("FAIL async_rst: out=%0d cout=%b ov=%b want 0 0 0",
                     o7, c7, ov7);
        end
        step();
        checks++;
        if ({o7, c7, ov7} !== 9'b0) begin
            errors++;
            $display("FAIL rst_ignore: out=%0d cout=%b ov=%b want 0 0 0",
                     o7, c7, ov7);
        end
        drive7(1'b0, 9, 9);
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if ({o7, c7, ov7} !== 9'b0) begin
            errors++;
            $display("FAIL post_rst: out=%0d cout=%b ov=%b want 0 0 0",
                     o7, c7, ov7);
        end
        drive7(1'b1, 9, 9);
        step();
        checks++;
        if (o7 !== 7'd81 || c7 !== 1'b0 || ov7 !== 1'b1) begin
            errors++;
            $display("FAIL first_cap: out=%0d cout=%b ov=%b want 81 0 1",
                     o7, c7, ov7);
        end
        drive7(1'b0, 0, 0);
    endtask

    task automatic test_sweep();
        int unsigned a;
        int unsigned b;
        int unsigned p;
        int bad = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i < 256) begin
                a = (i % 16) * 17;
                b = 255 - (i / 16) * 17;
            end else begin
                a = $urandom_range(255, 0);
                b = $urandom_range(255, 0);
            end
            v8 = 1'b1;
            a8 = 8'(a);
            b8 = 8'(b);
            p = a * b;
            step();
            checks++;
            if (o8 !== 8'(p) || c8 !== (p > 255) || ov8 !== 1'b1) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL sweep %0d*%0d: out=%0d cout=%b want %0d %b",
                             a, b, o8, c8, p & 255, p > 255);
            end
        end
        v8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_basic();
        test_overflow();
        test_hold_and_async_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
